press_generator: RTL and testbench

- Inverse of the button edge detector. Takes single-cycle press requests, for example from the computer-player logic, and produces a held button level.
- Each request becomes exactly one press: high for HOLD_CYCLES, then low for at least GAP_CYCLES.
- The output can drive any input that expects a human-style held button. Passing it through the edge-to-pulse converter yields exactly one pulse per accepted request.
- Requests arriving while a press is in progress are queued in a saturating counter.

---
 rtl/press_generator_if.sv | 28 ++
 rtl/press_generator.sv | 118 +++++++++++
 tb/tb_press_generator.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/press_generator_if.sv
// Request/press interface between a press requester (master) and press_generator (slave).
interface press_generator_if #(
  parameter int QUEUE_DEPTH = 3
);
  localparam int PW = $clog2(QUEUE_DEPTH + 1);

  logic          press_req;
  logic          button_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  modport master (
    output press_req,
    input  button_out,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  press_req,
    output button_out,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/press_generator.sv
// Turns single-cycle press requests into held button presses (HOLD high, then at
// least GAP low), queueing requests that arrive mid-press in a saturating counter.
module press_generator #(
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES  = 2,
  parameter int QUEUE_DEPTH = 3
) (
  input  logic              clk,
  input  logic              reset,
  press_generator_if.slave  bus
);
  localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);
  localparam int PW         = $clog2(QUEUE_DEPTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] QUEUE_FULL = PW'(QUEUE_DEPTH);

  logic [1:0]    state_q,    state_d;
  logic [TW-1:0] timer_q,    timer_d;
  logic [PW-1:0] pending_q,  pending_d;
  logic          button_q,   button_d;
  logic          overflow_q, overflow_d;

  logic timer_done;
  logic gap_exit;
  logic dequeue;
  logic queueing;

  assign timer_done = (timer_q == '0);
  assign gap_exit   = (state_q == S_GAP) && timer_done;
  assign dequeue    = gap_exit && (pending_q != '0);
  // A request on an empty-queue GAP exit starts the next press directly, like IDLE.
  assign queueing   = (state_q != S_IDLE) && !(gap_exit && (pending_q == '0));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    pending_d  = pending_q;
    button_d   = button_q;
    overflow_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.press_req) begin
          state_d  = S_HOLD;
          button_d = 1'b1;
          timer_d  = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (!timer_done) begin
          timer_d = timer_q - TW'(1);
        end else begin
          state_d  = S_GAP;
          button_d = 1'b0;
          timer_d  = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (!timer_done) begin
          timer_d = timer_q - TW'(1);
        end else if (pending_q != '0 || bus.press_req) begin
          state_d  = S_HOLD;
          button_d = 1'b1;
          timer_d  = HOLD_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        button_d = 1'b0;
        timer_d  = '0;
      end
    endcase

    if (queueing) begin
      // A request on a dequeue edge cancels out and can never overflow.
      unique case ({bus.press_req, dequeue})
        2'b10: begin
          if (pending_q == QUEUE_FULL) overflow_d = 1'b1;
          else                         pending_d  = pending_q + PW'(1);
        end
        2'b01:   pending_d = pending_q - PW'(1);
        default: pending_d = pending_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      pending_q  <= '0;
      button_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      button_q   <= button_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.button_out = button_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.pending    = pending_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_press_generator.sv
// Randomized scoreboard bench: two press_generator instances (3/2 and 1/1 timing) share
// one request stream and are compared every cycle against a press-schedule model.
module tb_press_generator;
  localparam int QD = 3;
  localparam int H0 = 3;
  localparam int G0 = 2;
  localparam int H1 = 1;
  localparam int G1 = 1;

  typedef struct {
    bit button;
    bit busy;
    int pending;
    bit overflow;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic press_req = 1'b0;

  press_generator_if #(.QUEUE_DEPTH(QD)) bus0 ();
  press_generator_if #(.QUEUE_DEPTH(QD)) bus1 ();

  assign bus0.press_req = press_req;
  assign bus1.press_req = press_req;

  press_generator #(.HOLD_CYCLES(H0), .GAP_CYCLES(G0), .QUEUE_DEPTH(QD)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  press_generator #(.HOLD_CYCLES(H1), .GAP_CYCLES(G1), .QUEUE_DEPTH(QD)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int   edge_idx;
  int   starts0[$];
  int   starts1[$];
  exp_t q0[$];
  exp_t q1[$];

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // The model holds the edge index at which every accepted press starts.  A request
  // at edge r starts at r if the previous press (hold + gap) is over, otherwise right
  // after it.  Pending = presses scheduled after the current edge.
  task automatic model_edge(input int q[$], input int r, input bit req,
                            input int h, input int g, input int qd,
                            output exp_t e, output int new_s);
    int  pend_before = 0;
    bit  deq         = 1'b0;
    bit  drop        = 1'b0;
    int  last        = -1000000;
    int  all_s[$];
    foreach (q[i]) begin
      if (q[i] >= r)   pend_before++;
      if (q[i] == r)   deq = 1'b1;
      if (q[i] > last) last = q[i];
    end
    new_s = -1;
    if (req) begin
      if (pend_before == qd && !deq) drop = 1'b1;
      else new_s = (r >= last + h + g) ? r : last + h + g;
    end
    all_s = q;
    if (new_s >= 0) all_s.push_back(new_s);
    e.button   = 1'b0;
    e.busy     = 1'b0;
    e.pending  = 0;
    e.overflow = drop;
    foreach (all_s[i]) begin
      if (all_s[i] <= r && r < all_s[i] + h)     e.button = 1'b1;
      if (all_s[i] <= r && r < all_s[i] + h + g) e.busy   = 1'b1;
      if (all_s[i] > r)                          e.pending++;
    end
  endtask

  task automatic drive(input bit req);
    exp_t e;
    int   ns;
    @(negedge clk);
    press_req = req;
    model_edge(starts0, edge_idx, req, H0, G0, QD, e, ns);
    if (ns >= 0) starts0.push_back(ns);
    q0.push_back(e);
    model_edge(starts1, edge_idx, req, H1, G1, QD, e, ns);
    if (ns >= 0) starts1.push_back(ns);
    q1.push_back(e);
    edge_idx++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".d0.button"},   32'(bus0.button_out), 0);
    check({tag, ".d0.busy"},     32'(bus0.busy),       0);
    check({tag, ".d0.pending"},  32'(bus0.pending),    0);
    check({tag, ".d0.overflow"}, 32'(bus0.overflow),   0);
    check({tag, ".d1.button"},   32'(bus1.button_out), 0);
    check({tag, ".d1.busy"},     32'(bus1.busy),       0);
    check({tag, ".d1.pending"},  32'(bus1.pending),    0);
    check({tag, ".d1.overflow"}, 32'(bus1.overflow),   0);
  endtask

  task automatic restart_model();
    starts0.delete();
    starts1.delete();
    edge_idx = 0;
  endtask

  // Monitor: every edge after release is an output event; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("d0.button",   32'(bus0.button_out), int'(e.button));
        check("d0.busy",     32'(bus0.busy),       int'(e.busy));
        check("d0.pending",  32'(bus0.pending),    e.pending);
        check("d0.overflow", 32'(bus0.overflow),   int'(e.overflow));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("d1.button",   32'(bus1.button_out), int'(e.button));
        check("d1.busy",     32'(bus1.busy),       int'(e.busy));
        check("d1.pending",  32'(bus1.pending),    e.pending);
        check("d1.overflow", 32'(bus1.overflow),   int'(e.overflow));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    restart_model();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // Single press, then three back-to-back requests.
    drive(1'b1); repeat (10) drive(1'b0);
    repeat (3) drive(1'b1); repeat (25) drive(1'b0);

    // Long burst: saturates the queue, drops, and hits dequeue-cancel edges.
    repeat (8) drive(1'b1); repeat (40) drive(1'b0);

    // Request held four cycles (the 1/1 instance alternates 1010101).
    repeat (4) drive(1'b1); repeat (15) drive(1'b0);

    // Fill the queue to 3, then request exactly on the GAP-exit edge of the 3/2 instance.
    repeat (4) drive(1'b1); drive(1'b0); drive(1'b1); repeat (40) drive(1'b0);

    repeat (1500) drive($urandom_range(0, 99) < 35);
    repeat (40) drive(1'b0);

    // Asynchronous reset between edges while the 3/2 instance is in HOLD with a queue.
    repeat (3) drive(1'b1);
    @(posedge clk);
    #3;
    press_req = 1'b0;
    reset     = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    restart_model();
    repeat (12) drive(1'b0);

    repeat (300) drive($urandom_range(0, 99) < 50);
    repeat (40) drive(1'b0);

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard0_drained", 32'(q0.size()), 0);
    check("scoreboard1_drained", 32'(q1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
